// File: rtl/mux_pipe_nx1.sv
// Two-stage pipelined N:1 word multiplexer with valid/ready flow control:
// stage 1 picks one word per group of eight, stage 2 picks the group.
// Optional feature macro: MUX_PIPE_OOR_ERR_EN (flag out-of-range selects on OOR, force Y to 0).

module mux_pipe_nx1 #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_INPUTS = 32,
   parameter int SEL_WIDTH  = 5
) (
   input  logic                             CLK,
   input  logic                             RST,
   input  logic [NUM_INPUTS*DATA_WIDTH-1:0] I,
   input  logic [SEL_WIDTH-1:0]             S,
   input  logic                             IN_VALID,
   output logic                             IN_READY,
   output logic [DATA_WIDTH-1:0]            Y,
   output logic                             OUT_VALID,
   input  logic                             OUT_READY,
   output logic                             OOR,
   output logic [15:0]                      XFER_CNT
);

   localparam int NUM_GROUPS = (NUM_INPUTS + 7) / 8;
   localparam int PAD_W      = NUM_GROUPS * 8 * DATA_WIDTH;
   // Select is widened so the group index always has at least one bit, even for tiny muxes.
   localparam int SEL_EXT_W  = (SEL_WIDTH < 4) ? 4 : SEL_WIDTH;
   localparam int HI_W       = SEL_EXT_W - 3;

   logic [SEL_EXT_W-1:0]  s_ext;
   logic [2:0]            s_lo;
   logic [HI_W-1:0]       s_hi;
   logic [PAD_W-1:0]      i_pad;
   logic [DATA_WIDTH-1:0] grp_word [NUM_GROUPS];
   logic                  adv;
   logic                  load1;
   logic                  load2;
   logic [DATA_WIDTH-1:0] y_sel;

   // Stage 1 state
   logic [DATA_WIDTH-1:0] p_d [NUM_GROUPS];
   logic [DATA_WIDTH-1:0] p_q [NUM_GROUPS];
   logic [HI_W-1:0]       s_hi_d, s_hi_q;
   logic                  v1_d, v1_q;

   // Stage 2 state
   logic [DATA_WIDTH-1:0] y_d, y_q;
   logic                  v2_d, v2_q;
   logic [15:0]           xfer_cnt_d, xfer_cnt_q;

`ifdef MUX_PIPE_OOR_ERR_EN
   logic                  range_oor;
   logic                  oor1_d, oor1_q;
   logic                  oor_d, oor_q;
`endif

   assign s_ext = SEL_EXT_W'(S);
   assign s_lo  = s_ext[2:0];
   assign s_hi  = s_ext[SEL_EXT_W-1:3];

   // Group-level 8:1 selection; the partial last group is padded with zero words.
   always_comb begin
      i_pad = PAD_W'(I);
      for (int g = 0; g < NUM_GROUPS; g++) begin
         // NOTE: every always_comb output gets a default first, so no path can infer a latch.
         grp_word[g] = '0;
         for (int j = 0; j < 8; j++) begin
            if (s_lo == 3'(j)) grp_word[g] = i_pad[(g*8 + j)*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Global stall: both stages advance together or hold together.
   assign adv   = !v2_q || OUT_READY;
   assign load1 = adv && IN_VALID;
   assign load2 = adv && v1_q;

   always_comb begin
      for (int g = 0; g < NUM_GROUPS; g++) begin
         p_d[g] = load1 ? grp_word[g] : p_q[g];
      end
      s_hi_d = load1 ? s_hi : s_hi_q;
      v1_d   = adv ? IN_VALID : v1_q;

      y_sel = '0;
      for (int g = 0; g < NUM_GROUPS; g++) begin
         if (s_hi_q == HI_W'(g)) y_sel = p_q[g];
      end
`ifdef MUX_PIPE_OOR_ERR_EN
      range_oor = (32'(S) >= NUM_INPUTS);
      oor1_d    = load1 ? range_oor : oor1_q;
      oor_d     = adv ? (v1_q && oor1_q) : oor_q;
      if (oor1_q) y_sel = '0;
`endif

      y_d        = load2 ? y_sel : y_q;
      v2_d       = adv ? v1_q : v2_q;
      xfer_cnt_d = xfer_cnt_q + 16'(v2_q && OUT_READY);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         // NOTE: the stage-1 word array is reset on purpose; after reset every data register reads 0.
         for (int g = 0; g < NUM_GROUPS; g++) begin
            p_q[g] <= '0;
         end
         s_hi_q     <= '0;
         v1_q       <= 1'b0;
         y_q        <= '0;
         v2_q       <= 1'b0;
         xfer_cnt_q <= '0;
`ifdef MUX_PIPE_OOR_ERR_EN
         oor1_q     <= 1'b0;
         oor_q      <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         for (int g = 0; g < NUM_GROUPS; g++) begin
            p_q[g] <= p_d[g];
         end
         s_hi_q     <= s_hi_d;
         v1_q       <= v1_d;
         y_q        <= y_d;
         v2_q       <= v2_d;
         xfer_cnt_q <= xfer_cnt_d;
`ifdef MUX_PIPE_OOR_ERR_EN
         oor1_q     <= oor1_d;
         oor_q      <= oor_d;
`endif
      end
   end

   assign IN_READY  = adv;
   assign Y         = y_q;
   assign OUT_VALID = v2_q;
   assign XFER_CNT  = xfer_cnt_q;
`ifdef MUX_PIPE_OOR_ERR_EN
   assign OOR       = oor_q;
`else
   assign OOR       = 1'b0;
`endif

endmodule

// File: tb/tb_mux_pipe_nx1.sv
// Scoreboard bench for mux_pipe_nx1: a 32-input instance for streaming, stall, reset and
// counter wrap, plus a 20-input instance for partial-group and out-of-range selects.

module tb_mux_pipe_nx1;

   localparam int DW  = 32;
   localparam int N   = 32;
   localparam int SW  = 5;
   localparam int N20 = 20;

   typedef struct packed {
      logic [DW-1:0] y;
      logic          oor;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n;

   logic [N*DW-1:0] i_bus;
   logic [SW-1:0]   s;
   logic            in_valid, in_ready, out_valid, out_ready, oor;
   logic [DW-1:0]   y;
   logic [15:0]     xfer_cnt;

   logic [N20*DW-1:0] i20;
   logic [SW-1:0]     s20;
   logic              v20, rdy20, ov20, or20, oor20;
   logic [DW-1:0]     y20;
   logic [15:0]       xfer20;

   logic [DW-1:0]   in_words [N];
   exp_t            sb [$];
   logic [15:0]     exp_cnt = '0;
   int              pass_cnt = 0;
   int              total_cnt = 0;

   mux_pipe_nx1 #(.DATA_WIDTH(DW), .NUM_INPUTS(N), .SEL_WIDTH(SW)) dut (
      .CLK(clk), .RST(rst_n), .I(i_bus), .S(s), .IN_VALID(in_valid), .IN_READY(in_ready),
      .Y(y), .OUT_VALID(out_valid), .OUT_READY(out_ready), .OOR(oor), .XFER_CNT(xfer_cnt));

   mux_pipe_nx1 #(.DATA_WIDTH(DW), .NUM_INPUTS(N20), .SEL_WIDTH(SW)) dut20 (
      .CLK(clk), .RST(rst_n), .I(i20), .S(s20), .IN_VALID(v20), .IN_READY(rdy20),
      .Y(y20), .OUT_VALID(ov20), .OUT_READY(or20), .OOR(oor20), .XFER_CNT(xfer20));

   always #5 clk = ~clk;

   always_comb begin
      for (int k = 0; k < N; k++) i_bus[k*DW +: DW] = in_words[k];
   end

   // Scoreboard: push on accepted input, pop and compare on delivered output.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n) begin
         if (out_valid && out_ready) begin
            total_cnt++;
            if (sb.size() == 0) begin
               $display("FAIL unexpected_word: got Y=%h with no word in flight", y);
            end else begin
               e = sb.pop_front();
               if (y !== e.y || oor !== e.oor)
                  $display("FAIL sb_word: got Y=%h OOR=%b, want Y=%h OOR=%b", y, oor, e.y, e.oor);
               else
                  pass_cnt++;
            end
            exp_cnt++;
         end
         if (in_valid && in_ready) sb.push_back('{y: in_words[s], oor: 1'b0});
      end
   end

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; s = '0;
      #12;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else pass_cnt++;
      total_cnt++; if (y !== '0) $display("FAIL rst_y: got %h want 0", y); else pass_cnt++;
      total_cnt++; if (oor !== 1'b0) $display("FAIL rst_oor: got %b want 0", oor); else pass_cnt++;
      total_cnt++; if (xfer_cnt !== 16'h0000) $display("FAIL rst_xfer_cnt: got %h want 0", xfer_cnt); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else pass_cnt++;
      @(negedge clk); rst_n = 1'b1;
      #1;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL rel_in_ready: got %b want 1", in_ready); else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL rel2_in_ready: got %b want 1", in_ready); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL rel_out_valid: got %b want 0", out_valid); else pass_cnt++;
   endtask

   task automatic test_stream();
      out_ready = 1'b1;
      for (int i = 0; i < 32; i++) begin
         s = SW'(i); in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total_cnt++; if (xfer_cnt !== 16'd32) $display("FAIL stream_xfer_cnt: got %0d want 32", xfer_cnt); else pass_cnt++;
      total_cnt++; if (sb.size() != 0) $display("FAIL stream_drain: got %0d words left want 0", sb.size()); else pass_cnt++;
   endtask

   task automatic test_stall();
      logic [15:0] cnt0;
      cnt0 = exp_cnt;
      out_ready = 1'b1; in_valid = 1'b1; s = 5'd1;
      @(posedge clk); #1;
      s = 5'd2;
      @(posedge clk); #1;
      s = 5'd3; out_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         total_cnt++; if (out_valid !== 1'b1 || y !== in_words[1])
            $display("FAIL stall_hold: got OUT_VALID=%b Y=%h want 1 %h", out_valid, y, in_words[1]); else pass_cnt++;
         total_cnt++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b want 0", in_ready); else pass_cnt++;
         total_cnt++; if (xfer_cnt !== cnt0) $display("FAIL stall_xfer_cnt: got %0d want %0d", xfer_cnt, cnt0); else pass_cnt++;
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total_cnt++; if (xfer_cnt !== 16'(cnt0 + 16'd3)) $display("FAIL stall_release_cnt: got %0d want %0d", xfer_cnt, cnt0 + 16'd3); else pass_cnt++;
      total_cnt++; if (sb.size() != 0) $display("FAIL stall_lost: got %0d words left want 0", sb.size()); else pass_cnt++;
   endtask

   task automatic test_reset_mid_stall();
      int seen;
      out_ready = 1'b1; in_valid = 1'b1; s = 5'd5;
      @(posedge clk); #1;
      s = 5'd6;
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL mrst_out_valid: got %b want 0", out_valid); else pass_cnt++;
      total_cnt++; if (y !== '0) $display("FAIL mrst_y: got %h want 0", y); else pass_cnt++;
      total_cnt++; if (xfer_cnt !== 16'h0000) $display("FAIL mrst_xfer_cnt: got %h want 0", xfer_cnt); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL mrst_in_ready: got %b want 1", in_ready); else pass_cnt++;
      sb.delete();
      exp_cnt = '0;
      @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
      seen = 0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); @(negedge clk);
         if (out_valid !== 1'b0) seen++;
      end
      @(posedge clk); #1;
      total_cnt++; if (seen != 0) $display("FAIL mrst_stale: got %0d stale valid cycles want 0", seen); else pass_cnt++;
      total_cnt++; if (xfer_cnt !== 16'h0000) $display("FAIL mrst_after_cnt: got %h want 0", xfer_cnt); else pass_cnt++;
   endtask

   task automatic test_toggle();
      logic iv [24];
      logic want;
      out_ready = 1'b1;
      for (int t = 0; t < 24; t++) begin
         for (int k = 0; k < N; k++) in_words[k] = $urandom;
         s = SW'($urandom_range(0, 31));
         in_valid = (t < 16) && (t % 2 == 0);
         iv[t] = in_valid;
         @(negedge clk);
         want = (t >= 2) ? iv[t-2] : 1'b0;
         total_cnt++; if (out_valid !== want) $display("FAIL toggle_valid_t%0d: got %b want %b", t, out_valid, want); else pass_cnt++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      for (int k = 0; k < N; k++) in_words[k] = 32'h0101_0101 * 32'(k);
      total_cnt++; if (xfer_cnt !== 16'd8) $display("FAIL toggle_cnt: got %0d want 8", xfer_cnt); else pass_cnt++;
   endtask

   task automatic test_wrap();
      int n;
      n = 65535 - int'(exp_cnt);
      out_ready = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < n; i++) begin
         s = SW'(i % 32);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total_cnt++; if (xfer_cnt !== 16'hFFFF) $display("FAIL wrap_full: got %h want ffff", xfer_cnt); else pass_cnt++;
      s = 5'd9; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total_cnt++; if (xfer_cnt !== 16'h0000) $display("FAIL wrap_zero: got %h want 0000", xfer_cnt); else pass_cnt++;
      total_cnt++; if (sb.size() != 0) $display("FAIL wrap_drain: got %0d words left want 0", sb.size()); else pass_cnt++;
   endtask

   task automatic test_oor20();
      int sels [9] = '{25, 19, 20, 23, 0, 7, 8, 16, 31};
      logic [DW-1:0] exp_y;
      logic exp_oor, check_y;
      or20 = 1'b1;
      for (int i = 0; i < 9; i++) begin
         exp_oor = 1'b0; check_y = 1'b1;
         if (sels[i] < N20) begin
            exp_y = 32'hA500_0000 | 32'(sels[i]);
         end else begin
            exp_y = '0;
`ifdef MUX_PIPE_OOR_ERR_EN
            exp_oor = 1'b1;
`else
            check_y = (sels[i] < 24);
`endif
         end
         s20 = SW'(sels[i]); v20 = 1'b1;
         @(posedge clk); #1;
         v20 = 1'b0;
         @(posedge clk); @(negedge clk);
         total_cnt++; if (ov20 !== 1'b1) $display("FAIL n20_valid_s%0d: got %b want 1", sels[i], ov20); else pass_cnt++;
         total_cnt++; if (oor20 !== exp_oor) $display("FAIL n20_oor_s%0d: got %b want %b", sels[i], oor20, exp_oor); else pass_cnt++;
         if (check_y) begin
            total_cnt++; if (y20 !== exp_y) $display("FAIL n20_y_s%0d: got %h want %h", sels[i], y20, exp_y); else pass_cnt++;
         end
         @(posedge clk); #1;
      end
      total_cnt++; if (xfer20 !== 16'd9) $display("FAIL n20_cnt: got %0d want 9", xfer20); else pass_cnt++;
   endtask

   initial begin
      for (int k = 0; k < N; k++) in_words[k] = 32'h0101_0101 * 32'(k);
      for (int k = 0; k < N20; k++) i20[k*DW +: DW] = 32'hA500_0000 | 32'(k);
      s20 = '0; v20 = 1'b0; or20 = 1'b1;
      test_reset();
      test_stream();
      test_stall();
      test_reset_mid_stall();
      test_toggle();
      test_wrap();
      test_oor20();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
